// File: rtl/linear_layer_fifo_pkg.sv
// ----------------------------------------------------------------------------
// linear_layer_fifo_pkg
// Shared types and elaboration-time helpers for the start-token FIFO that sits
// between the feeder/loader and the PE_i4xi4_pack_2x2 consumer.
//   - DEF_* localparams : default configuration of the start FIFO
//   - ptr_t             : read-pointer type for the default configuration
//   - depth_legal()     : DEPTH must be at least 2
//   - min_addr_width()  : smallest pointer width that can address DEPTH entries
//   - depth_fits()      : DEPTH <= 2**ADDR_WIDTH
// ----------------------------------------------------------------------------
package linear_layer_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 1;
    localparam int DEF_ADDR_WIDTH = 2;
    localparam int DEF_DEPTH      = 4;

    typedef logic [DEF_ADDR_WIDTH-1:0] ptr_t;

    function automatic bit depth_legal(input int depth);
        return depth >= 2;
    endfunction

    function automatic int min_addr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic bit depth_fits(input int depth, input int addr_width);
        return (addr_width >= min_addr_width(depth)) && (depth <= (1 << addr_width));
    endfunction

endpackage

// File: rtl/linear_layer_start_fifo_srl.sv
// ----------------------------------------------------------------------------
// linear_layer_start_fifo_srl
// Shift-register storage for the start-token FIFO. No reset: contents are only
// meaningful where the controller's occupancy says so.
// Ports:
//   clk  : clock, rising edge
//   we   : shift enable; entry 0 takes din, every other entry takes its neighbour
//   addr : read index (0 = newest entry)
//   din  : data shifted in
//   dout : combinational read of entry addr
// ----------------------------------------------------------------------------
module linear_layer_start_fifo_srl
    import linear_layer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem[i] <= mem[i-1];
            end
            mem[0] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/linear_layer_start_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// linear_layer_start_fifo_ctrl
// Start-token FIFO controller: owns the full/empty flags, the occupancy
// counter and the read pointer, and drives the SRL storage.
// Optional feature macro: START_FIFO_OCCUPANCY_EN (adds occupancy outputs).
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   if_write_ce       : write-side clock enable
//   if_write, if_din  : producer write request and data
//   if_full_n         : registered, 1 = space available
//   if_read_ce        : read-side clock enable
//   if_read           : consumer read request
//   if_dout           : head token, valid while if_empty_n = 1
//   if_empty_n        : registered, 1 = data available
//   if_num_data_valid : (macro only) registered occupancy count
//   if_fifo_cap       : (macro only) constant DEPTH
// Handshake: a write is accepted when if_write_ce & if_write & if_full_n, a
// read when if_read_ce & if_read & if_empty_n, using only the registered flags.
// ----------------------------------------------------------------------------
module linear_layer_start_fifo_ctrl
    import linear_layer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
`ifdef START_FIFO_OCCUPANCY_EN
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap,
`endif
    output logic                  if_empty_n
);

    if (!depth_legal(DEPTH)) begin : g_depth_legal_check
        $error("linear_layer_start_fifo_ctrl: DEPTH must be at least 2");
    end
    if (!depth_fits(DEPTH, ADDR_WIDTH)) begin : g_depth_fit_check
        $error("linear_layer_start_fifo_ctrl: DEPTH exceeds 2**ADDR_WIDTH");
    end

    typedef logic [ADDR_WIDTH:0]   cnt_t;
    typedef logic [ADDR_WIDTH-1:0] rptr_t;

    localparam cnt_t  CNT_ONE   = cnt_t'(1);
    localparam cnt_t  CNT_DEPTH = cnt_t'(DEPTH);
    localparam rptr_t PTR_ONE   = rptr_t'(1);

    cnt_t  count;
    rptr_t rd_ptr;
    logic  full_n;
    logic  empty_n;
    logic  push;
    logic  pop;

    assign push = if_write_ce & if_write & full_n;
    assign pop  = if_read_ce  & if_read  & empty_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            rd_ptr  <= '0;
            full_n  <= 1'b1;
            empty_n <= 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    count   <= count + CNT_ONE;
                    // First token lands in entry 0, which is already the head.
                    if (empty_n) rd_ptr <= rd_ptr + PTR_ONE;
                    empty_n <= 1'b1;
                    full_n  <= (count + CNT_ONE) != CNT_DEPTH;
                end
                2'b01: begin
                    count   <= count - CNT_ONE;
                    // Popping the last token leaves the pointer parked at 0.
                    if (count != CNT_ONE) rd_ptr <= rd_ptr - PTR_ONE;
                    full_n  <= 1'b1;
                    empty_n <= count != CNT_ONE;
                end
                // Push+pop: storage shifts under a fixed pointer, so the head
                // advances to the next-oldest token with no bookkeeping change.
                default: ;
            endcase
        end
    end

    assign if_full_n  = full_n;
    assign if_empty_n = empty_n;

`ifdef START_FIFO_OCCUPANCY_EN
    assign if_num_data_valid = count;
    assign if_fifo_cap       = CNT_DEPTH;
`endif

    linear_layer_start_fifo_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk  (clk),
        .we   (push),
        .addr (rd_ptr),
        .din  (if_din),
        .dout (if_dout)
    );

endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_linear_layer_start_fifo_ctrl
// Directed and random traffic against linear_layer_start_fifo_ctrl
// (DATA_WIDTH=8, DEPTH=4). The reference is a plain token queue: accepted
// writes append, accepted reads remove the oldest, reset empties it.
// ----------------------------------------------------------------------------
module tb_linear_layer_start_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    // Clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          if_write_ce = 1'b0;
    logic          if_write    = 1'b0;
    logic [DW-1:0] if_din      = '0;
    logic          if_read_ce  = 1'b0;
    logic          if_read     = 1'b0;
    logic          if_full_n;
    logic          if_empty_n;
    logic [DW-1:0] if_dout;
`ifdef START_FIFO_OCCUPANCY_EN
    logic [AW:0]   if_num_data_valid;
    logic [AW:0]   if_fifo_cap;
`endif

    linear_layer_start_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_write_ce       (if_write_ce),
        .if_write          (if_write),
        .if_din            (if_din),
        .if_full_n         (if_full_n),
        .if_read_ce        (if_read_ce),
        .if_read           (if_read),
        .if_dout           (if_dout),
`ifdef START_FIFO_OCCUPANCY_EN
        .if_num_data_valid (if_num_data_valid),
        .if_fifo_cap       (if_fifo_cap),
`endif
        .if_empty_n        (if_empty_n)
    );

    // Scoreboard
    logic [DW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic exp_empty_n;
        logic exp_full_n;
        exp_empty_n = (exp_q.size() != 0);
        exp_full_n  = (exp_q.size() != DEPTH);
        expect_val({tag, "/empty_n"}, 32'(if_empty_n), 32'(exp_empty_n));
        expect_val({tag, "/full_n"},  32'(if_full_n),  32'(exp_full_n));
        if (exp_q.size() != 0)
            expect_val({tag, "/dout"}, 32'(if_dout), 32'(exp_q[0]));
`ifdef START_FIFO_OCCUPANCY_EN
        expect_val({tag, "/num_valid"}, 32'(if_num_data_valid), 32'(exp_q.size()));
        expect_val({tag, "/cap"},       32'(if_fifo_cap),       32'(DEPTH));
`endif
    endtask

    // Driver: apply one cycle of inputs, then update the reference and check.
    task automatic cycle(input bit wce, input bit w, input logic [DW-1:0] d,
                         input bit rce, input bit r, input bit rst, input string tag);
        bit acc_w;
        bit acc_r;
        if_write_ce = wce;
        if_write    = w;
        if_din      = d;
        if_read_ce  = rce;
        if_read     = r;
        reset       = rst;
        acc_w = wce && w && (exp_q.size() < DEPTH);
        acc_r = rce && r && (exp_q.size() > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (acc_r) void'(exp_q.pop_front());
            if (acc_w) exp_q.push_back(d);
        end
        check_model(tag);
    endtask

    logic [DW-1:0] fill_vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        // Reset, idle, rejected read
        cycle(0, 0, 8'h00, 0, 0, 1, "reset");
        cycle(0, 0, 8'h00, 0, 0, 1, "reset2");
        expect_val("rst_empty_n", 32'(if_empty_n), 32'(0));
        expect_val("rst_full_n",  32'(if_full_n),  32'(1));
        cycle(0, 0, 8'h00, 1, 1, 0, "idle_read");
        expect_val("idle_read_empty_n", 32'(if_empty_n), 32'(0));

        // Fill to full, fifth write dropped
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, fill_vals[i], 0, 0, 0, "fill");
            expect_val("fill_empty_n", 32'(if_empty_n), 32'(1));
        end
        expect_val("full_after_4", 32'(if_full_n), 32'(0));
        cycle(1, 1, 8'h55, 0, 0, 0, "write_when_full");
        expect_val("full_hold", 32'(if_full_n), 32'(0));

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            expect_val("drain_dout", 32'(if_dout), 32'(fill_vals[i]));
            cycle(0, 0, 8'h00, 1, 1, 0, "drain");
            expect_val("drain_full_n", 32'(if_full_n), 32'(1));
        end
        expect_val("drain_empty", 32'(if_empty_n), 32'(0));

        // Two held, simultaneous push+pop
        cycle(1, 1, 8'hA1, 0, 0, 0, "hold2");
        cycle(1, 1, 8'hA2, 0, 0, 0, "hold2");
        for (int i = 0; i < 3; i++) begin
            logic [DW-1:0] want;
            want = DW'(8'hA1 + i);
            expect_val("pushpop_dout", 32'(if_dout), 32'(want));
            cycle(1, 1, DW'(8'hA3 + i), 1, 1, 0, "pushpop");
            expect_val("pushpop_empty_n", 32'(if_empty_n), 32'(1));
            expect_val("pushpop_full_n",  32'(if_full_n),  32'(1));
        end
        cycle(0, 0, 8'h00, 1, 1, 0, "pushpop_drain");
        cycle(0, 0, 8'h00, 1, 1, 0, "pushpop_drain");
        expect_val("pushpop_drained", 32'(if_empty_n), 32'(0));

        // Full with push+pop: pop wins, push rejected
        for (int i = 0; i < 4; i++) cycle(1, 1, DW'(8'hB0 + i), 0, 0, 0, "refill");
        cycle(1, 1, 8'hBF, 1, 1, 0, "full_pushpop");
        expect_val("full_pushpop_full_n", 32'(if_full_n), 32'(1));
        expect_val("full_pushpop_head",   32'(if_dout),   32'(8'hB1));
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1, 1, 0, "full_pushpop_drain");

        // Reset with three held; tokens must not reappear
        for (int i = 0; i < 3; i++) cycle(1, 1, DW'(8'hC0 + i), 0, 0, 0, "pre_reset");
        cycle(1, 1, 8'hEE, 1, 1, 1, "mid_reset");
        expect_val("mid_reset_empty_n", 32'(if_empty_n), 32'(0));
        expect_val("mid_reset_full_n",  32'(if_full_n),  32'(1));
        cycle(1, 1, 8'h77, 0, 0, 0, "post_reset_write");
        expect_val("post_reset_dout", 32'(if_dout), 32'(8'h77));
        cycle(0, 0, 8'h00, 1, 1, 0, "post_reset_pop");

        // Random traffic, including clock-enable gating and occasional reset
        for (int n = 0; n < 600; n++) begin
            cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                  DW'($urandom_range(0, 255)),
                  bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 63) == 0), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
